// File: rtl/mem_io_unit_pkg.sv
// Shared types and widths for the memory I/O unit.
package mem_io_unit_pkg;

  localparam int unsigned MEM_DATA_W = 12;
  localparam int unsigned BUS_DATA_W = 8;
  localparam int unsigned ADDR_W     = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } state_e;

  // Extend a loaded byte to the pipeline data width.
  function automatic logic [MEM_DATA_W-1:0] extend_byte(input logic [BUS_DATA_W-1:0] b,
                                                         input logic                  sgn);
    return {{(MEM_DATA_W - BUS_DATA_W){sgn & b[BUS_DATA_W-1]}}, b};
  endfunction

endpackage

// File: rtl/mem_beat_timer.sv
// Per-beat wait counter; flags the cycle on which the wait limit is reached.
module mem_beat_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count cycles spent without an acknowledge; clear wins over enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Expire on the unacknowledged cycle that brings the count up to the limit; 0 disables.
  always_comb begin
    expired_o = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

endmodule

// File: rtl/mem_io_unit.sv
// Converts pipeline loads/stores into one or two byte beats on a req/ack bus.
module mem_io_unit
  import mem_io_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic                  req_wide,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     address,
  input  logic [MEM_DATA_W-1:0] mem_write_data,
  output logic [MEM_DATA_W-1:0] mem_read_data,
  output logic                  stall,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [BUS_DATA_W-1:0] bus_wdata,
  input  logic [BUS_DATA_W-1:0] bus_rdata,
  input  logic                  bus_ack
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  wide_q, wide_d;
  logic                  sgn_q, sgn_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [BUS_DATA_W-1:0] lo_q, lo_d;
  logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [BUS_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic                  timer_clear;
  logic                  timer_enable;
  logic                  timer_expired;

  mem_beat_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk_i    (clock),
    .rst_ni   (nreset),
    .clear_i  (timer_clear),
    .enable_i (timer_enable),
    .expired_o(timer_expired)
  );

  // State and registered bus/result outputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      wide_q      <= 1'b0;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wide_q      <= wide_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Next-state, request latching, beat sequencing and load-result capture.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    wide_d       = wide_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d     = StLo;
          we_d        = req_we;
          wide_d      = req_wide;
          sgn_d       = req_signed;
          addr_d      = address;
          wdata_d     = mem_write_data;
          bus_req_d   = 1'b1;
          bus_we_d    = req_we;
          bus_addr_d  = address;
          bus_wdata_d = mem_write_data[7:0];
          timer_clear = 1'b1;
        end
      end
      StLo: begin
        timer_enable = !bus_ack;
        if (bus_ack) begin
          if (!we_q) lo_d = bus_rdata;
          if (wide_q) begin
            // Keep bus_req high straight into the high beat.
            state_d     = StHi;
            bus_addr_d  = addr_q + 16'd1;
            bus_wdata_d = {4'h0, wdata_q[11:8]};
            timer_clear = 1'b1;
          end else begin
            state_d   = StDone;
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
            if (!we_q) rdata_d = extend_byte(bus_rdata, sgn_q);
          end
        end else if (timer_expired) begin
          state_d   = StDone;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          err_d     = 1'b1;
          if (!we_q) rdata_d = '0;
        end
      end
      StHi: begin
        timer_enable = !bus_ack;
        if (bus_ack) begin
          state_d   = StDone;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (!we_q) rdata_d = {bus_rdata[3:0], lo_q};
        end else if (timer_expired) begin
          state_d   = StDone;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          err_d     = 1'b1;
          if (!we_q) rdata_d = '0;
        end
      end
      StDone: begin
        // The finishing instruction still drives req_valid here, so it is ignored.
        state_d = StIdle;
      end
    endcase
  end

  // Stall covers the launch cycle and both beats, releasing in DONE.
  always_comb begin
    stall = ((state_q == StIdle) && req_valid) || (state_q == StLo) || (state_q == StHi);
  end

  assign mem_read_data = rdata_q;
  assign bus_err       = err_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit with a 4-cycle beat timeout.
module tb_mem_io_unit;

  logic        clock;
  logic        nreset;
  logic        req_valid;
  logic        req_we;
  logic        req_wide;
  logic        req_signed;
  logic [15:0] address;
  logic [11:0] mem_write_data;
  logic [11:0] mem_read_data;
  logic        stall;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;

  int checks;
  int errors;

  mem_io_unit #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_wide      (req_wide),
    .req_signed    (req_signed),
    .address       (address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .stall         (stall),
    .bus_err       (bus_err),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ack       (bus_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic        wide;
    logic        sgn;
    logic [15:0] addr;
    logic [11:0] wdata;
    int          waits;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          e_stall;
    int          e_acks;
    logic [15:0] e_a0;
    logic [15:0] e_a1;
    logic [7:0]  e_w0;
    logic [7:0]  e_w1;
    logic        e_we;
    logic        e_err;
    logic [11:0] e_rd;
  } vec_t;

  vec_t vecs[8];

  // Results of the last run_access.
  int          r_stall;
  int          r_acks;
  logic [15:0] r_a0, r_a1;
  logic [7:0]  r_w0, r_w1;
  logic        r_we0, r_we1;
  logic        r_err, r_req_done, r_fin;
  logic [11:0] r_rd;
  logic        r_idle_stall, r_idle_req, r_idle_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one access and play the bus slave: ack each beat after v.waits wait cycles.
  task automatic run_access(input vec_t v);
    int  waitc;
    logic got0, got1;
    @(negedge clock);
    req_valid      = 1'b1;
    req_we         = v.we;
    req_wide       = v.wide;
    req_signed     = v.sgn;
    address        = v.addr;
    mem_write_data = v.wdata;
    bus_ack        = 1'b0;
    r_stall = 0; r_acks = 0; waitc = 0; got0 = 1'b0; got1 = 1'b0;
    r_a0 = '0; r_a1 = '0; r_w0 = '0; r_w1 = '0; r_we0 = 1'b0; r_we1 = 1'b0;
    r_fin = 1'b0; r_err = 1'b0; r_req_done = 1'b0; r_rd = '0;
    for (int cyc = 0; cyc < 40 && !r_fin; cyc++) begin
      #1;
      if (!stall) begin
        r_fin      = 1'b1;
        r_err      = bus_err;
        r_req_done = bus_req;
        r_rd       = mem_read_data;
      end else begin
        r_stall++;
        bus_ack   = 1'b0;
        bus_rdata = 8'hC3;
        if (bus_req) begin
          if (r_acks == 0 && !got0) begin
            r_a0 = bus_addr; r_w0 = bus_wdata; r_we0 = bus_we; got0 = 1'b1;
          end else if (r_acks == 1 && !got1) begin
            r_a1 = bus_addr; r_w1 = bus_wdata; r_we1 = bus_we; got1 = 1'b1;
          end
          if (waitc == v.waits) begin
            bus_ack   = 1'b1;
            bus_rdata = (r_acks == 0) ? v.lo : v.hi;
            r_acks++;
            waitc = 0;
          end else begin
            waitc++;
          end
        end
        @(negedge clock);
        bus_ack = 1'b0;
      end
    end
    // Drop the request after DONE and look at the following IDLE cycle.
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    r_idle_stall = stall;
    r_idle_req   = bus_req;
    r_idle_err   = bus_err;
  endtask

  task automatic check_access(input string tag, input vec_t v);
    check({tag, " done"}, 32'(r_fin), 32'(1));
    check({tag, " stall"}, 32'(r_stall), 32'(v.e_stall));
    check({tag, " acks"}, 32'(r_acks), 32'(v.e_acks));
    check({tag, " addr0"}, 32'(r_a0), 32'(v.e_a0));
    check({tag, " wdata0"}, 32'(r_w0), 32'(v.e_w0));
    check({tag, " we0"}, 32'(r_we0), 32'(v.e_we));
    if (v.e_acks == 2) begin
      check({tag, " addr1"}, 32'(r_a1), 32'(v.e_a1));
      check({tag, " wdata1"}, 32'(r_w1), 32'(v.e_w1));
      check({tag, " we1"}, 32'(r_we1), 32'(v.e_we));
    end
    check({tag, " err"}, 32'(r_err), 32'(v.e_err));
    check({tag, " req_in_done"}, 32'(r_req_done), 32'(0));
    check({tag, " rdata"}, 32'(r_rd), 32'(v.e_rd));
    check({tag, " idle_stall"}, 32'(r_idle_stall), 32'(0));
    check({tag, " idle_req"}, 32'(r_idle_req), 32'(0));
    check({tag, " idle_err"}, 32'(r_idle_err), 32'(0));
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    nreset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0; req_signed = 1'b0;
    address = '0; mem_write_data = '0; bus_rdata = '0; bus_ack = 1'b0;

    //            we wide sgn addr      wdata  wt  lo     hi     stl acks a0        a1        w0     w1     we   err  rd
    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h1234, 12'h000, 0, 8'h80, 8'h00, 2, 1, 16'h1234, 16'h0000,
                8'h00, 8'h00, 1'b0, 1'b0, 12'hF80};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h1234, 12'h000, 0, 8'h80, 8'h00, 2, 1, 16'h1234, 16'h0000,
                8'h00, 8'h00, 1'b0, 1'b0, 12'h080};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h2000, 12'h000, 2, 8'h5A, 8'hF3, 7, 2, 16'h2000, 16'h2001,
                8'h00, 8'h00, 1'b0, 1'b0, 12'h35A};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 12'hABC, 0, 8'h00, 8'h00, 3, 2, 16'hFFFF, 16'h0000,
                8'hBC, 8'h0A, 1'b1, 1'b0, 12'h35A};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0010, 12'h7E5, 1, 8'h00, 8'h00, 3, 1, 16'h0010, 16'h0000,
                8'hE5, 8'h00, 1'b1, 1'b0, 12'h35A};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0020, 12'h000, 3, 8'h7F, 8'h00, 5, 1, 16'h0020, 16'h0000,
                8'h00, 8'h00, 1'b0, 1'b0, 12'h07F};
    // Never acknowledged: four unacked cycles then abort.
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'h4000, 12'h000, 99, 8'h00, 8'h00, 5, 0, 16'h4000, 16'h0000,
                8'h00, 8'h00, 1'b0, 1'b1, 12'h000};
    // Wide load ignores req_signed and bus_rdata[7:4] of the high beat.
    vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h1000, 12'h000, 0, 8'hFF, 8'hA8, 3, 2, 16'h1000, 16'h1001,
                8'h00, 8'h00, 1'b0, 1'b0, 12'h8FF};

    // Reset values while nreset is held low.
    #12;
    check("rst rdata", 32'(mem_read_data), 32'(0));
    check("rst stall", 32'(stall), 32'(0));
    check("rst bus_req", 32'(bus_req), 32'(0));
    check("rst bus_we", 32'(bus_we), 32'(0));
    check("rst bus_err", 32'(bus_err), 32'(0));
    check("rst bus_addr", 32'(bus_addr), 32'(0));
    check("rst bus_wdata", 32'(bus_wdata), 32'(0));
    @(negedge clock);
    nreset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i]);
      check_access($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset during the high beat of a wide load.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b1; req_signed = 1'b0;
    address = 16'h5550; mem_write_data = 12'h000;
    @(negedge clock);
    #1;
    check("midhi lo_req", 32'(bus_req), 32'(1));
    bus_ack = 1'b1; bus_rdata = 8'h11;
    @(negedge clock);
    bus_ack = 1'b0;
    #1;
    check("midhi hi_req", 32'(bus_req), 32'(1));
    check("midhi hi_addr", 32'(bus_addr), 32'(16'h5551));
    req_valid = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    check("midhi rst bus_req", 32'(bus_req), 32'(0));
    check("midhi rst stall", 32'(stall), 32'(0));
    check("midhi rst bus_addr", 32'(bus_addr), 32'(0));
    check("midhi rst rdata", 32'(mem_read_data), 32'(0));
    @(negedge clock);
    nreset = 1'b1;
    v = '{1'b0, 1'b0, 1'b1, 16'h3000, 12'h000, 0, 8'hC1, 8'h00, 2, 1, 16'h3000, 16'h0000,
          8'h00, 8'h00, 1'b0, 1'b0, 12'hFC1};
    run_access(v);
    check_access("after_rst", v);

    // req_valid held through DONE must not relaunch; it launches only from IDLE.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b0; req_signed = 1'b0;
    address = 16'h0100; mem_write_data = 12'h000;
    #1;
    check("hold idle_stall", 32'(stall), 32'(1));
    @(negedge clock);
    #1;
    check("hold lo_req", 32'(bus_req), 32'(1));
    bus_ack = 1'b1; bus_rdata = 8'h42;
    @(negedge clock);
    bus_ack = 1'b0;
    #1;
    check("hold done_stall", 32'(stall), 32'(0));
    check("hold done_rdata", 32'(mem_read_data), 32'(12'h042));
    @(negedge clock);
    #1;
    check("hold idle_req", 32'(bus_req), 32'(0));
    check("hold idle_stall2", 32'(stall), 32'(1));
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    check("hold relaunch_req", 32'(bus_req), 32'(1));
    check("hold relaunch_addr", 32'(bus_addr), 32'(16'h0100));
    bus_ack = 1'b1; bus_rdata = 8'h99;
    @(negedge clock);
    bus_ack = 1'b0;
    #1;
    check("hold relaunch_rdata", 32'(mem_read_data), 32'(12'h099));
    @(negedge clock);
    #1;
    check("hold final_req", 32'(bus_req), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_unit.md
Name: mem_io_unit

Overview:
Memory I/O unit sitting directly below the memory pipeline stage. It consumes the stage's 16-bit address and 12-bit store data, and returns the 12-bit (already extended) load result. It converts each load/store into one or two 8-bit transactions on an external req/ack memory bus. It stalls the pipeline until the access completes or times out.

Parameters:
TIMEOUT_CYCLES, 255, cycles waiting for bus_ack per beat before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clock  in  1  system clock, rising edge.
nreset  in  1  asynchronous active-low reset.
req_valid  in  1  memory access requested by the instruction in the memory stage.
req_we  in  1  1 = store, 0 = load.
req_wide  in  1  1 = 12-bit access (two bytes), 0 = byte access.
req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
address  in  16  access address from the memory stage.
mem_write_data  in  12  store data from the memory stage.
mem_read_data  out  12  load result, extended to 12 bits.
stall  out  1  holds the pipeline while an access is in progress.
bus_err  out  1  one-cycle pulse when an access is aborted by timeout.
bus_req  out  1  external bus request.
bus_we  out  1  external write enable.
bus_addr  out  16  external byte address.
bus_wdata  out  8  external write data.
bus_rdata  in  8  external read data, valid when bus_ack = 1.
bus_ack  in  1  external acknowledge; completes the current beat.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; mem_read_data = 0x000; bus_req, bus_we, bus_err, stall-source flops = 0; bus_addr = 0x0000; bus_wdata = 0x00.
- Reset mid-transaction: the access is abandoned and bus_req drops immediately; no completion is signalled.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - On req_valid = 1, latch we/wide/signed/address/write data and go to LO.
  - stall is combinational: stall = (IDLE & req_valid) | LO | HI.
- LO:
  - bus_req = 1, bus_addr = latched address, bus_we = latched we, bus_wdata = wdata[7:0].
  - On bus_ack: a load captures bus_rdata as the low byte. Go to HI if wide, else DONE.
- HI:
  - bus_addr = address + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
  - bus_wdata = {4'h0, wdata[11:8]}.
  - On bus_ack: a load captures bus_rdata[3:0] and ignores bus_rdata[7:4]. Go to DONE.
- Bus outputs (bus_req, bus_we, bus_addr, bus_wdata) are registered and held stable until ack is sampled high.
  - An ack in the same cycle the request is first presented is valid.
  - Consecutive LO→HI beats keep bus_req high with no gap cycle.
  - bus_req = 0 in IDLE and DONE.
- DONE:
  - stall = 0; the pipeline advances on this edge. Always return to IDLE next cycle.
  - req_valid is ignored in DONE, because the same instruction is still presenting it.
- mem_read_data is updated at the DONE transition for loads only and held until the next load completes. Stores leave it unchanged.
  - Byte load: mem_read_data = {4{b[7]}, b} if signed, else {4'h0, b}.
  - Wide load: {hi[3:0], lo[7:0]}; req_signed is ignored.
- Latency with zero-wait ack: byte access stalls 2 cycles; wide access stalls 3 cycles. Each wait cycle adds 1.
- Timeout:
  - The counter clears on entering LO or HI and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES: abort to DONE. A load sets mem_read_data = 0x000. bus_err pulses high for the DONE cycle only.
- Changes on req_valid or input fields during LO/HI are ignored; bus transactions are never cancelled except by reset.

Decomposition:
- Shared package: state encoding (IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3), MEM_DATA_W = 12, BUS_DATA_W = 8, ADDR_W = 16.
- One sub-module, mem_beat_timer: CNT_W counter with clear, enable and an expired output compared against TIMEOUT_CYCLES. The FSM, latches and extend logic stay in mem_io_unit.

Test Plan:
- Signed byte load: addr 0x1234, bus_rdata 0x80, ack on first cycle -> bus_addr 0x1234, stall high for 2 cycles, mem_read_data 0xF80. Unsigned variant -> 0x080.
- Wide load with 2 wait states per beat: lo 0x5A, hi 0xF3 -> bus_addr 0x2000 then 0x2001, stall high for 7 cycles, mem_read_data 0x35A.
- Wide store at 0xFFFF, data 0xABC -> beat 1 addr 0xFFFF wdata 0xBC we=1; beat 2 addr 0x0000 wdata 0x0A; mem_read_data unchanged.
- Timeout with TIMEOUT_CYCLES=4 and ack never asserted on a load -> abort after 4 cycles, bus_err single pulse, mem_read_data 0x000, bus_req 0 in DONE.
- Reset mid-HI: nreset low asynchronously -> bus_req, stall and state clear within the same cycle; the next req_valid starts a fresh LO beat.
- req_valid held high through DONE -> no second access launched; an access launches only when req_valid is high while in IDLE.
